// File: rtl/spongent_sponge_ctrl_pkg.sv
// rtl/spongent_sponge_ctrl_pkg.sv - shared constants, FSM encoding and lane helper for the sponge sequencer
package spongent_sponge_ctrl_pkg;

  localparam int RATE_BYTES = 11;   // bytes absorbed per block
  localparam int STATE_BITS = 264;  // permutation width b
  localparam int HASH_BITS  = 88;   // digest width, fits in one squeeze
  localparam int LANE_W     = $clog2(STATE_BITS);

  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam logic [3:0] RATE_IDX = 4'(RATE_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    PAD,
    PERM,
    DONE
  } fsm_t;

  // Bit offset of rate byte idx inside the state vector.
  function automatic logic [LANE_W-1:0] lane_base(input logic [3:0] idx);
    return LANE_W'({idx, 3'b000});
  endfunction

endpackage

// File: rtl/spongent_sponge_ctrl.sv
// rtl/spongent_sponge_ctrl.sv - sponge-mode absorb/pad/permute/squeeze sequencer for SPONGENT
//  clk, rst            clock, async active-high reset
//  msg_byte/valid/last message byte stream, msg_ready = accept
//  perm_start          one-cycle launch of the external permutation
//  perm_state_in       state handed to the permutation (held while it runs)
//  perm_state_out/done permuted state and its one-cycle completion pulse
//  hash_out/valid/ack  digest, held valid until acknowledged
//  busy                high whenever the sequencer is not idle
module spongent_sponge_ctrl
  import spongent_sponge_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            msg_byte,
  input  logic                  msg_valid,
  input  logic                  msg_last,
  output logic                  msg_ready,
  output logic                  perm_start,
  output logic [STATE_BITS-1:0] perm_state_in,
  input  logic [STATE_BITS-1:0] perm_state_out,
  input  logic                  perm_done,
  output logic [HASH_BITS-1:0]  hash_out,
  output logic                  hash_valid,
  input  logic                  hash_ack,
  output logic                  busy
);

  fsm_t                  fsm, fsm_nxt;
  logic [STATE_BITS-1:0] state, state_nxt;
  logic [3:0]            idx, idx_nxt;
  logic                  final_pend, final_nxt;
  logic                  pad_pend, pad_nxt;
  logic                  perm_issued, issued_nxt;
  logic [HASH_BITS-1:0]  hash_out_nxt;
  logic                  hash_valid_nxt;
  logic [LANE_W-1:0]     lane;

  assign lane          = lane_base(idx);
  assign perm_state_in = state;
  assign busy          = (fsm != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  // msg_ready is registered from the next state so it is 0 in reset and
  // exactly tracks IDLE/ABSORB afterwards without a reset term in logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= '0;
      idx         <= '0;
      final_pend  <= 1'b0;
      pad_pend    <= 1'b0;
      perm_issued <= 1'b0;
      hash_out    <= '0;
      hash_valid  <= 1'b0;
      msg_ready   <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      final_pend  <= final_nxt;
      pad_pend    <= pad_nxt;
      perm_issued <= issued_nxt;
      hash_out    <= hash_out_nxt;
      hash_valid  <= hash_valid_nxt;
      msg_ready   <= (fsm_nxt == IDLE) || (fsm_nxt == ABSORB);
    end
  end

  always_comb begin
    fsm_nxt        = fsm;
    state_nxt      = state;
    idx_nxt        = idx;
    final_nxt      = final_pend;
    pad_nxt        = pad_pend;
    issued_nxt     = perm_issued;
    hash_out_nxt   = hash_out;
    hash_valid_nxt = hash_valid;
    perm_start     = 1'b0;

    unique case (fsm)
      IDLE, ABSORB: begin
        if (msg_valid && msg_ready) begin
          state_nxt[lane +: 8] = state[lane +: 8] ^ msg_byte;
          idx_nxt              = idx + 4'd1;
          fsm_nxt              = ABSORB;
          if (idx_nxt == RATE_IDX) begin
            // Full block: permute now; if it was also the last byte the
            // padding goes into a fresh block afterwards.
            fsm_nxt   = PERM;
            final_nxt = 1'b0;
            pad_nxt   = msg_last;
          end else if (msg_last) begin
            fsm_nxt = PAD;
          end
        end
      end

      PAD: begin
        state_nxt[lane +: 8] = state[lane +: 8] ^ PAD_BYTE;
        final_nxt            = 1'b1;
        fsm_nxt              = PERM;
      end

      PERM: begin
        perm_start = !perm_issued;
        issued_nxt = 1'b1;
        // perm_done may coincide with perm_start for a zero-wait core.
        if (perm_done) begin
          state_nxt  = perm_state_out;
          idx_nxt    = '0;
          issued_nxt = 1'b0;
          if (final_pend) begin
            fsm_nxt        = DONE;
            hash_out_nxt   = perm_state_out[HASH_BITS-1:0];
            hash_valid_nxt = 1'b1;
          end else if (pad_pend) begin
            pad_nxt = 1'b0;
            fsm_nxt = PAD;
          end else begin
            fsm_nxt = ABSORB;
          end
        end
      end

      DONE: begin
        if (hash_ack) begin
          hash_valid_nxt = 1'b0;
          state_nxt      = '0;
          final_nxt      = 1'b0;
          fsm_nxt        = IDLE;
        end
      end

      default: fsm_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spongent_sponge_ctrl.sv
// tb/tb_spongent_sponge_ctrl.sv - self-checking bench for spongent_sponge_ctrl with stub permutation
module tb_spongent_sponge_ctrl;

  localparam int RB = 11;
  localparam int SB = 264;
  localparam int HB = 88;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    msg_byte;
  logic          msg_valid;
  logic          msg_last;
  logic          msg_ready;
  logic          perm_start;
  logic [SB-1:0] perm_state_in;
  logic [SB-1:0] perm_state_out;
  logic          perm_done;
  logic [HB-1:0] hash_out;
  logic          hash_valid;
  logic          hash_ack;
  logic          busy;

  spongent_sponge_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .msg_byte       (msg_byte),
    .msg_valid      (msg_valid),
    .msg_last       (msg_last),
    .msg_ready      (msg_ready),
    .perm_start     (perm_start),
    .perm_state_in  (perm_state_in),
    .perm_state_out (perm_state_out),
    .perm_done      (perm_done),
    .hash_out       (hash_out),
    .hash_valid     (hash_valid),
    .hash_ack       (hash_ack),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [SB-1:0] obs, input logic [SB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stub permutation: XOR with A5 bytes, done three cycles after start.
  localparam logic [SB-1:0] A5S = {33{8'hA5}};
  logic [SB-1:0] stub_data = '0;
  logic [1:0]    stub_cnt  = '0;
  logic          stub_done = 1'b0;
  logic          spur      = 1'b0;
  logic [SB-1:0] spur_data = '0;

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (perm_start) begin
      stub_cnt  <= 2'd2;
      stub_data <= perm_state_in ^ A5S;
    end else if (stub_cnt != 2'd0) begin
      stub_cnt <= stub_cnt - 2'd1;
      if (stub_cnt == 2'd1) stub_done <= 1'b1;
    end
  end

  assign perm_done      = stub_done | spur;
  assign perm_state_out = stub_done ? stub_data : spur_data;

  // Monitor: capture every permutation input and start cycle, count digest
  // rises, and check msg_ready stays low while a permutation or digest is live.
  logic [SB-1:0] cap_q[$];
  int            start_q[$];
  int            hv_rises = 0;
  logic          hv_prev  = 1'b0;
  logic          inflight = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      hv_prev  <= 1'b0;
    end else begin
      if (perm_start) begin
        cap_q.push_back(perm_state_in);
        start_q.push_back(cyc);
      end
      if (inflight || hash_valid || perm_start) chk("ready_excl", {263'd0, msg_ready}, '0);
      if (perm_start && !perm_done) inflight <= 1'b1;
      else if (perm_done)           inflight <= 1'b0;
      if (hash_valid && !hv_prev) hv_rises <= hv_rises + 1;
      hv_prev <= hash_valid;
    end
  end

  // Reference model: pad with 0x80 then zeros to whole blocks, XOR each block
  // into the state and apply the stub permutation.
  logic [7:0]    msg_q[$];
  logic [SB-1:0] exp_in_q[$];
  logic [HB-1:0] exp_dig;

  task automatic model();
    logic [7:0]    p[$];
    logic [SB-1:0] st;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % RB != 0) p.push_back(8'h00);
    st = '0;
    exp_in_q.delete();
    for (int b = 0; b < p.size() / RB; b++) begin
      for (int k = 0; k < RB; k++) st[8*k +: 8] = st[8*k +: 8] ^ p[b*RB + k];
      exp_in_q.push_back(st);
      st = st ^ A5S;
    end
    exp_dig = st[HB-1:0];
  endtask

  function automatic logic [SB-1:0] rand_state();
    logic [SB-1:0] r;
    for (int i = 0; i < SB / 8; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  int last_acc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit got;
    msg_byte  = b;
    msg_valid = 1'b1;
    msg_last  = last;
    got       = 1'b0;
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      if (msg_ready) begin
        got      = 1'b1;
        last_acc = cyc;
      end
      step();
    end
    if (!got) chk("accept_timeout", 0, 1);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic run_msg(input bit gaps, input int hold);
    int n, base_cap, base_rise, blk;
    bit seen;
    n         = msg_q.size();
    base_cap  = cap_q.size();
    base_rise = hv_rises;
    model();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          msg_valid = 1'b0;
          msg_last  = 1'($urandom_range(0, 1));
          if (msg_ready && $urandom_range(0, 1) == 1) begin
            spur      = 1'b1;
            spur_data = rand_state();
          end
          step();
          spur = 1'b0;
        end
      end
      send_byte(msg_q[i], i == n - 1);
    end

    seen = 1'b0;
    for (int w = 0; w < 500 && !seen; w++) begin
      @(negedge clk);
      if (hash_valid) seen = 1'b1;
    end
    chk("hash_timeout", {263'd0, seen}, 1);

    chk("perm_count", cap_q.size() - base_cap, exp_in_q.size());
    for (int j = 0; j < exp_in_q.size(); j++)
      if (base_cap + j < cap_q.size()) chk("perm_in", cap_q[base_cap + j], exp_in_q[j]);
    blk = (n - 1) / RB;
    if (base_cap + blk < start_q.size())
      chk("start_latency", start_q[base_cap + blk] - last_acc, (n % RB == 0) ? 1 : 2);
    chk("digest", hash_out, exp_dig);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {263'd0, hash_valid}, 1);
      chk("hold_out", hash_out, exp_dig);
    end

    step();
    hash_ack = 1'b1;
    step();
    hash_ack = 1'b0;
    chk("ack_valid", {263'd0, hash_valid}, 0);
    chk("ack_busy", {263'd0, busy}, 0);
    chk("ack_retain", hash_out, exp_dig);
    chk("valid_once", hv_rises - base_rise, 1);
  endtask

  task automatic load_abc();
    msg_q = {8'h61, 8'h62, 8'h63};
  endtask

  task automatic load_rand(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  logic [HB-1:0] abc_dig;
  int            cap0;

  initial begin
    rst       = 1'b1;
    msg_byte  = '0;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    hash_ack  = 1'b0;
    repeat (3) step();
    chk("rst_ready", {263'd0, msg_ready}, 0);
    chk("rst_start", {263'd0, perm_start}, 0);
    chk("rst_state_in", perm_state_in, '0);
    chk("rst_hash", hash_out, '0);
    chk("rst_hvalid", {263'd0, hash_valid}, 0);
    chk("rst_busy", {263'd0, busy}, 0);
    rst = 1'b0;
    step();

    // "abc": single block, digest held for 20 cycles before ack.
    load_abc();
    cap0 = cap_q.size();
    run_msg(1'b0, 20);
    chk("abc_in_lo", cap_q[cap0][31:0], 32'h80636261);
    chk("abc_in_hi", cap_q[cap0][SB-1:32], '0);
    chk("abc_digest", hash_out, {11{8'hA5}} ^ 88'h80636261);
    abc_dig = hash_out;

    // Same message again must give the same digest from a zero IV.
    load_abc();
    run_msg(1'b0, 0);
    chk("abc_repeat", hash_out, abc_dig);

    // Exactly one full block: padding lands in a second block.
    msg_q.delete();
    for (int i = 0; i < RB; i++) msg_q.push_back(8'(i));
    cap0 = cap_q.size();
    run_msg(1'b0, 0);
    chk("full_in1", cap_q[cap0][87:0], 88'h0A090807060504030201_00);
    chk("full_in2_b0", cap_q[cap0 + 1][7:0], 8'h25);

    // Boundary lengths around the rate.
    load_rand(12); run_msg(1'b0, 0);
    load_rand(1);  run_msg(1'b0, 0);
    load_rand(10); run_msg(1'b0, 0);
    load_rand(22); run_msg(1'b0, 0);
    load_rand(23); run_msg(1'b0, 0);

    // Abort during PERM with asynchronous reset.
    msg_q.delete();
    for (int i = 0; i < RB; i++) send_byte(8'(i + 16), 1'b0);
    for (int w = 0; w < 10 && !inflight; w++) step();
    chk("abort_inflight", {263'd0, inflight}, 1);
    #3 rst = 1'b1;
    #1;
    chk("abort_ready", {263'd0, msg_ready}, 0);
    chk("abort_start", {263'd0, perm_start}, 0);
    chk("abort_state_in", perm_state_in, '0);
    chk("abort_hash", hash_out, '0);
    chk("abort_hvalid", {263'd0, hash_valid}, 0);
    chk("abort_busy", {263'd0, busy}, 0);
    step();
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("late_done_busy", {263'd0, busy}, 0);
    chk("late_done_hvalid", {263'd0, hash_valid}, 0);
    load_abc();
    run_msg(1'b0, 0);
    chk("abc_after_abort", hash_out, abc_dig);

    // Random lengths with valid gaps and spurious perm_done pulses.
    for (int m = 0; m < 8; m++) begin
      load_rand($urandom_range(1, 30));
      run_msg(1'b1, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
